// File: rtl/dzcpu_ucode_sequencer.sv
// Writable microcode sequencer for dzcpu: macro-opcode handshake, loadable dispatch tables and micro-store.
// Optional undefined-opcode trap is enabled by defining DZCPU_UCODE_UNDEF_TRAP_EN.
module dzcpu_ucode_sequencer #(
    parameter int         UOP_W     = 13,
    parameter int         UPC_W     = 8,
    parameter logic [7:0] PREFIX_OP = 8'hCB
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic [7:0]       iMop,
    input  logic             iMopValid,
    output logic             oMopReady,
    input  logic             iStall,
    input  logic             iCond,
    output logic [UOP_W-1:0] oUop,
    output logic             oUopValid,
    output logic [UPC_W-1:0] oUpc,
    input  logic             iLdEn,
    input  logic [1:0]       iLdSel,
    input  logic [UPC_W-1:0] iLdAddr,
    input  logic [UOP_W-1:0] iLdData,
    output logic             oLdBusy,
    output logic             oUndefOp
);
    localparam int DEPTH = 1 << UPC_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef DZCPU_UCODE_UNDEF_TRAP_EN
        S_CB   = 2'd2,
        S_TRAP = 2'd3
`else
        S_CB   = 2'd2
`endif
    } state_t;

    logic [UOP_W-1:0] r_store   [DEPTH];
    logic [UPC_W-1:0] r_primary [256];
    logic [UPC_W-1:0] r_cb      [256];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [UPC_W-1:0] r_upc;
    logic [UPC_W-1:0] w_upc_nxt;
    logic [UOP_W-1:0] r_uop;
    logic [UOP_W-1:0] w_uop_nxt;
    logic             r_uop_valid;
    logic             w_valid_nxt;
    logic             w_fetch;
    logic [UPC_W-1:0] w_disp_upc;
    logic [1:0]       w_flow;
    logic             w_ld_ok;
    logic             w_unused;

    // PREFIX_OP only documents table content; dispatch is driven by the flow field.
    assign w_unused   = ^PREFIX_OP;
    assign w_flow     = r_uop[UOP_W-1 -: 2];
    assign w_disp_upc = (r_state == S_CB) ? r_cb[iMop] : r_primary[iMop];
    assign w_ld_ok    = iLdEn & (r_state == S_IDLE) & ~iMopValid;
    assign w_uop_nxt  = w_fetch ? r_store[w_upc_nxt] : r_uop;

    assign oMopReady = (r_state == S_IDLE) || (r_state == S_CB);
    assign oLdBusy   = iLdEn & ~w_ld_ok;
    assign oUop      = r_uop;
    assign oUopValid = r_uop_valid;
    assign oUpc      = r_upc;

`ifdef DZCPU_UCODE_UNDEF_TRAP_EN
    logic r_undef;
    logic w_undef_nxt;
    assign oUndefOp = r_undef;
`else
    assign oUndefOp = 1'b0;
`endif

    // Table and micro-store writes; contents survive reset.
    always_ff @(posedge iClock) begin
        if (w_ld_ok) begin
            case (iLdSel)
                2'd0:    r_store[iLdAddr]          <= iLdData;
                2'd1:    r_primary[iLdAddr[7:0]]   <= iLdData[UPC_W-1:0];
                2'd2:    r_cb[iLdAddr[7:0]]        <= iLdData[UPC_W-1:0];
                default: ;
            endcase
        end
    end

    // Next-state: dispatch from idle/prefix wait, flow evaluation while running.
    always_comb begin
        w_state_nxt = r_state;
        w_upc_nxt   = r_upc;
        w_valid_nxt = r_uop_valid;
        w_fetch     = 1'b0;
`ifdef DZCPU_UCODE_UNDEF_TRAP_EN
        w_undef_nxt = r_undef;
`endif
        case (r_state)
            S_IDLE, S_CB: begin
                if (iMopValid) begin
`ifdef DZCPU_UCODE_UNDEF_TRAP_EN
                    if (w_disp_upc == {UPC_W{1'b0}}) begin
                        w_state_nxt = S_TRAP;
                        w_undef_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_upc_nxt   = w_disp_upc;
                        w_valid_nxt = 1'b1;
                        w_fetch     = 1'b1;
                    end
`else
                    w_state_nxt = S_RUN;
                    w_upc_nxt   = w_disp_upc;
                    w_valid_nxt = 1'b1;
                    w_fetch     = 1'b1;
`endif
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RUN: begin
                if (iStall) begin
                    w_state_nxt = S_RUN;
                end else begin
                    case (w_flow)
                        2'b00: begin
                            w_upc_nxt = r_upc + {{(UPC_W-1){1'b0}}, 1'b1};
                            w_fetch   = 1'b1;
                        end
                        2'b01: begin
                            w_state_nxt = S_IDLE;
                            w_valid_nxt = 1'b0;
                        end
                        2'b10: begin
                            w_state_nxt = S_CB;
                            w_valid_nxt = 1'b0;
                        end
                        2'b11: begin
                            if (iCond) begin
                                w_state_nxt = S_IDLE;
                                w_valid_nxt = 1'b0;
                            end else begin
                                w_upc_nxt = r_upc + {{(UPC_W-1){1'b0}}, 1'b1};
                                w_fetch   = 1'b1;
                            end
                        end
                        default: w_state_nxt = S_RUN;
                    endcase
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // State and registered micro-op outputs.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state     <= S_IDLE;
            r_upc       <= {UPC_W{1'b0}};
            r_uop       <= {UOP_W{1'b0}};
            r_uop_valid <= 1'b0;
`ifdef DZCPU_UCODE_UNDEF_TRAP_EN
            r_undef     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_upc       <= w_upc_nxt;
            r_uop       <= w_uop_nxt;
            r_uop_valid <= w_valid_nxt;
`ifdef DZCPU_UCODE_UNDEF_TRAP_EN
            r_undef     <= w_undef_nxt;
`endif
        end
    end
endmodule
